// File: rtl/pwm_fan_driver.sv
// Fan PWM driver: converts the signed controller output into a PWM duty that is
// ramp-limited, kick-started from standstill and only updated on period boundaries.
module pwm_fan_driver #(
   parameter int ADC_BITWIDTH = 8,
   parameter int PRESCALER    = 4,
   parameter int RAMP_STEP    = 4,
   parameter int KICK_PERIODS = 8
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic                          enable_i,
   input  logic signed [ADC_BITWIDTH:0]  out_Val_i,
   output logic                          pwm_o,
   output logic                          period_strb_o,
   output logic [ADC_BITWIDTH-1:0]       duty_o,
   output logic [1:0]                    state_o
);

   localparam int N   = ADC_BITWIDTH;
   localparam int NP1 = N + 1;
   localparam int KW  = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;

   localparam logic [7:0]    PRESC_MAX = 8'(PRESCALER - 1);
   localparam logic [N-1:0]  CNT_MAX   = N'((1 << N) - 2);
   localparam logic [N-1:0]  DUTY_FULL = '1;
   localparam logic [N:0]    STEP      = NP1'(RAMP_STEP);
   localparam logic [KW-1:0] KICK_LOAD = KW'(KICK_PERIODS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      KICK = 2'd2
   } state_t;

   state_t        state_q;
   logic [7:0]    presc_q;
   logic [N-1:0]  cnt_q;
   logic [N-1:0]  duty_q;
   logic [KW-1:0] kickCnt_q;
   logic          pwm_q;
   logic          strb_q;

   logic          tick;
   logic          boundary;
   logic [N-1:0]  target;
   logic [N:0]    targetWide;
   logic [N:0]    dutyWide;
   logic [N-1:0]  effDuty;
   logic [N-1:0]  ramp_d;
   logic          pwm_d;

   // The counter stops one short of all-ones so that a full-scale duty keeps pwm high.
   assign tick       = (presc_q == PRESC_MAX);
   assign boundary   = (state_q != IDLE) && tick && (cnt_q == CNT_MAX);
   assign target     = out_Val_i[N] ? '0 : out_Val_i[N-1:0];
   assign targetWide = {1'b0, target};
   assign dutyWide   = {1'b0, duty_q};
   assign effDuty    = (state_q == KICK) ? DUTY_FULL : duty_q;
   assign pwm_d      = (state_q != IDLE) && (cnt_q < effDuty);

   // Differences are taken in N+1 bits so a step can never wrap past 0 or full scale.
   always_comb begin
      ramp_d = target;
      if (targetWide > dutyWide) begin
         if ((targetWide - dutyWide) > STEP) begin
            ramp_d = duty_q + STEP[N-1:0];
         end
      end else if ((dutyWide - targetWide) > STEP) begin
         ramp_d = duty_q - STEP[N-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         duty_q    <= '0;
         kickCnt_q <= '0;
         pwm_q     <= 1'b0;
         strb_q    <= 1'b0;
      end else if (!enable_i) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         cnt_q     <= '0;
         duty_q    <= '0;
         kickCnt_q <= '0;
         pwm_q     <= 1'b0;
         strb_q    <= 1'b0;
      end else begin
         pwm_q  <= pwm_d;
         strb_q <= boundary;
         if (state_q != IDLE) begin
            presc_q <= tick ? '0 : presc_q + 8'd1;
            if (tick) begin
               cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + N'(1);
            end
         end
         case (state_q)
            IDLE: begin
               state_q   <= RUN;
               presc_q   <= '0;
               cnt_q     <= '0;
               duty_q    <= '0;
               kickCnt_q <= '0;
            end
            RUN: begin
               if (boundary) begin
                  if ((duty_q == '0) && (target != '0)) begin
                     state_q   <= KICK;
                     kickCnt_q <= KICK_LOAD;
                     duty_q    <= DUTY_FULL;
                  end else begin
                     duty_q <= ramp_d;
                  end
               end
            end
            KICK: begin
               if (boundary) begin
                  if (kickCnt_q != '0) begin
                     kickCnt_q <= kickCnt_q - KW'(1);
                  end else begin
                     state_q <= RUN;
                     duty_q  <= target;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               presc_q   <= '0;
               cnt_q     <= '0;
               duty_q    <= '0;
               kickCnt_q <= '0;
            end
         endcase
      end
   end

   assign pwm_o         = pwm_q;
   assign period_strb_o = strb_q;
   assign duty_o        = duty_q;
   assign state_o       = state_q;

endmodule

// File: doc/pwm_fan_driver.md
PWM_FAN_DRIVER -- requirements
Module: pwm_fan_driver

Interface
REQ-001 Parameter ADC_BITWIDTH, default 8, width N of the duty value; the input is N+1 bits signed.
REQ-002 Parameter PRESCALER, default 4, clk_i cycles per PWM count tick (legal range 1..255).
REQ-003 Parameter RAMP_STEP, default 4, maximum duty change per PWM period in RUN.
REQ-004 Parameter KICK_PERIODS, default 8, number of full-duty PWM periods applied when starting from zero duty.
REQ-005 clk_i  input  1  single system clock; all state changes on its rising edge.
REQ-006 rstn_i  input  1  reset, asynchronous and active-low.
REQ-007 enable_i  input  1  run request; low forces the idle state.
REQ-008 out_Val_i  input  N+1 signed  controller output (PID_core out_Val_o), sampled only at period boundaries.
REQ-009 pwm_o  output  1  registered fan PWM drive.
REQ-010 period_strb_o  output  1  registered one-cycle pulse at every period boundary.
REQ-011 duty_o  output  N  duty currently applied to the comparator.
REQ-012 state_o  output  2  current FSM state: IDLE=0, RUN=1, KICK=2.

Function
REQ-013 A prescaler shall count 0..PRESCALER-1 and wrap, with tick=1 in the cycle where it equals PRESCALER-1.
REQ-014 A period counter cnt shall advance on each tick over 0..2^N-2 and wrap to 0, giving a period of PRESCALER*(2^N-1) clocks (1020 by default).
REQ-015 A boundary shall be the cycle where tick=1 and cnt=2^N-2; period_strb_o shall be 1 in the following cycle only.
REQ-016 Target shall be 0 if out_Val_i<0, else out_Val_i[N-1:0].
REQ-017 pwm_o shall be registered as (state!=IDLE) AND (cnt<duty), with the effective duty 2^N-1 in KICK, so duty 255 gives 100% high and duty 0 gives constant low.
REQ-018 IDLE: prescaler, cnt, duty and kick counter held at 0; pwm_o=0; on enable_i=1, go to RUN next cycle with the counters starting from 0.
REQ-019 RUN, at a boundary with duty=0 and target>0: go to KICK, load kick counter=KICK_PERIODS-1, and set duty_o=2^N-1.
REQ-020 RUN, at any other boundary: duty moves toward target by min(RAMP_STEP, |target-duty|), with no overflow or underflow (unsigned N+1-bit compare).
REQ-021 KICK, at a boundary with kick counter>0: decrement the kick counter.
REQ-022 KICK, at a boundary with kick counter=0: go to RUN and set duty=target directly, with no ramp.
REQ-023 If target becomes 0 during KICK, KICK shall still complete, then duty=0.
REQ-024 Duty shall change only at boundaries, so no PWM period is ever truncated or glitched while enabled.
REQ-025 enable_i=0 in any state shall force IDLE on the next edge, with pwm_o=0 from that edge; enable_i takes priority over a simultaneous boundary.
REQ-026 Re-enable after IDLE shall restart from duty 0, so the kick applies again if target>0.
REQ-027 The block shall be fully synchronous except for the asynchronous clear.

Reset
REQ-028 While rstn_i=0, all registers shall clear asynchronously: state=IDLE, pwm_o=0, period_strb_o=0, duty_o=0, and counters 0.
REQ-029 Reset deassertion mid-period shall resume in IDLE and ignore enable_i until the first edge after release.
REQ-030 Reset asserted during KICK or RUN shall abandon the operation with no residual pulse on pwm_o.

Verification
REQ-031 Reset release, enable_i=1, out_Val_i=+100 -> state RUN, then KICK at first boundary (clk 1020); duty_o=255 and pwm_o constant high for 8 periods, then duty_o=100 with high time of 400 clk per 1020.
REQ-032 From steady duty 100, out_Val_i=+110 -> duty_o=104, 108, 110 at successive boundaries; each period_strb_o exactly 1 cycle wide, 1020 clk apart.
REQ-033 out_Val_i=-50 from duty 10 -> duty_o=6, 2, 0 at successive boundaries; pwm_o then constant low and no kick while target is 0 (duty 0, target 0).
REQ-034 out_Val_i=+255 steady in RUN -> pwm_o constant high across a wrap; out_Val_i=0 with duty 0 -> pwm_o never high.
REQ-035 enable_i dropped mid-KICK in the cycle of a boundary -> IDLE next edge, pwm_o=0, duty_o=0; re-enable with +100 -> full 8-period kick repeats.
REQ-036 rstn_i pulsed low asynchronously between clock edges while pwm_o=1 -> pwm_o=0 immediately, before the next clock edge; all outputs at reset values.
